// File: rtl/robs_datapath.sv
// Datapath for Robertson's signed multiplier: holds M, Q, A, F and the step counter Y,
// executes one add/sub-then-shift microinstruction per cycle and registers the 2N-bit product.
module robs_datapath #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [14:0]           c,
    input  logic signed [N-1:0]   x,
    input  logic signed [N-1:0]   y,
    output logic                  zq,
    output logic                  zy,
    output logic                  zr,
    output logic signed [2*N-1:0] product,
    output logic                  p_valid
);
    localparam int YW = $clog2(N + 1);

    logic signed [N-1:0]   r_m;
    logic signed [N-1:0]   r_q;
    logic signed [N-1:0]   r_a;
    logic                  r_f;
    logic [YW-1:0]         r_y;
    logic signed [2*N-1:0] r_product;
    logic                  r_p_valid;

    logic signed [N:0]     w_fa_clr;
    logic signed [N:0]     w_m_ext;
    logic signed [N:0]     w_sum;
    logic signed [N-1:0]   w_a_next;
    logic signed [N-1:0]   w_q_next;
    logic                  w_f_next;
    logic [4:0]            w_unused;

    assign w_unused = c[14:10];

    // Clear -> add/sub -> shift all resolve within one microinstruction.
    always_comb begin
        w_fa_clr = {(c[3] ? 1'b0 : r_f), (c[2] ? {N{1'b0}} : r_a)};
        w_m_ext  = {r_m[N-1], r_m};
        w_sum    = w_fa_clr;
        if (c[6])
            w_sum = w_fa_clr - w_m_ext;
        else if (c[5])
            w_sum = w_fa_clr + w_m_ext;

        w_f_next = w_sum[N];
        w_a_next = w_sum[N-1:0];
        w_q_next = r_q;
        if (c[7]) begin
            w_a_next = w_sum[N:1];
            w_q_next = {w_sum[0], r_q[N-1:1]};
        end
        // A multiplier load overrides the Q shift; the A shift still happens.
        if (c[1])
            w_q_next = y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m       <= '0;
            r_q       <= '0;
            r_a       <= '0;
            r_f       <= 1'b0;
            r_y       <= '0;
            r_product <= '0;
            r_p_valid <= 1'b0;
        end else begin
            if (c[0])
                r_m <= x;
            r_q <= w_q_next;
            r_a <= w_a_next;
            r_f <= w_f_next;
            if (c[4])
                r_y <= YW'(N);
            else if (c[8])
                r_y <= r_y - YW'(1);
            if (c[9])
                r_product <= {r_a, r_q};
            r_p_valid <= c[9];
        end
    end

    // Flags come from registers only, so there is no loop through the sequencer.
    assign zq      = r_q[0];
    assign zy      = (r_y == '0);
    assign zr      = (r_m == '0);
    assign product = r_product;
    assign p_valid = r_p_valid;
endmodule

// File: tb/tb_robs_datapath.sv
// Directed bench for robs_datapath: an integer-arithmetic model checked every cycle,
// plus hand-computed product and flag expectations.
module tb_robs_datapath;
    localparam logic [14:0] C_LDM   = 15'h0001;
    localparam logic [14:0] C_LDQ   = 15'h0002;
    localparam logic [14:0] C_CLRA  = 15'h0004;
    localparam logic [14:0] C_CLRF  = 15'h0008;
    localparam logic [14:0] C_SETY  = 15'h0010;
    localparam logic [14:0] C_ADD   = 15'h0020;
    localparam logic [14:0] C_SUB   = 15'h0040;
    localparam logic [14:0] C_SHR   = 15'h0080;
    localparam logic [14:0] C_DEC   = 15'h0100;
    localparam logic [14:0] C_LATCH = 15'h0200;
    localparam logic [14:0] C_LOAD  = C_LDM | C_LDQ | C_CLRA | C_CLRF | C_SETY;

    logic               clk = 1'b0;
    logic               reset;
    logic [14:0]        c;
    logic signed [7:0]  x;
    logic signed [7:0]  y;
    logic               zq, zy, zr;
    logic signed [15:0] product;
    logic               p_valid;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state as plain integers: value of M, unsigned A and Q bytes, F bit, counter, product.
    int m_m = 0, m_a = 0, m_f = 0, m_q = 0, m_y = 0, m_prod = 0, m_pv = 0;

    robs_datapath #(.N(8)) dut (
        .clk(clk), .reset(reset), .c(c), .x(x), .y(y),
        .zq(zq), .zy(zy), .zr(zr), .product(product), .p_valid(p_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int acc;
        int nq;
        if (reset) begin
            m_m <= 0; m_a <= 0; m_f <= 0; m_q <= 0; m_y <= 0; m_prod <= 0; m_pv <= 0;
        end else begin
            acc = (c[3] ? 0 : m_f) * (-256) + (c[2] ? 0 : m_a);
            if (c[6])      acc = acc - m_m;
            else if (c[5]) acc = acc + m_m;
            acc = acc & 511;
            if (acc >= 256) acc = acc - 512;
            nq = m_q;
            if (c[7]) begin
                nq  = (m_q >> 1) + (acc & 1) * 128;
                acc = acc >>> 1;
            end
            if (c[1]) nq = int'(y) & 255;
            if (c[0]) m_m <= int'(x);
            m_a <= acc & 255;
            m_f <= (acc < 0) ? 1 : 0;
            m_q <= nq;
            if (c[4]) m_y <= 8;
            else if (c[8]) begin
                if (m_y == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL y_underflow: decrement issued with counter 0 at %0t", $time);
                end
                m_y <= (m_y + 15) % 16;
            end
            if (c[9]) m_prod <= m_a * 256 + m_q;
            m_pv <= c[9] ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("zq", int'(zq), m_q & 1);
            check("zy", int'(zy), (m_y == 0) ? 1 : 0);
            check("zr", int'(zr), (m_m == 0) ? 1 : 0);
            check("product", int'(product) & 65535, m_prod & 65535);
            check("p_valid", int'(p_valid), m_pv);
        end
    end

    task automatic run_mult(input int xv, input int yv, input int exp_prod);
        logic [14:0] cw;
        @(negedge clk); c = C_LOAD; x = 8'(xv); y = 8'(yv);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cw = C_SHR | C_DEC;
            if ((m_q & 1) == 1) cw = cw | ((i == 7) ? C_SUB : C_ADD);
            c = cw;
        end
        @(negedge clk);
        check("zy_at_latch", int'(zy), 1);
        c = C_LATCH;
        @(negedge clk);
        c = '0;
        check("pv_pulse", int'(p_valid), 1);
        check("prod_literal", int'(product) & 65535, exp_prod);
        check("prod_arith", int'(product) & 65535, (xv * yv) & 65535);
        @(negedge clk);
        check("pv_single", int'(p_valid), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; c = '0; x = '0; y = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_product", int'(product), 0);
        check("rst_pvalid", int'(p_valid), 0);
        check("rst_zq", int'(zq), 0);
        check("rst_zy", int'(zy), 1);
        check("rst_zr", int'(zr), 1);

        // Reset in the middle of a multiply, then a clean multiply.
        @(negedge clk); c = C_LOAD; x = 8'sd5; y = 8'sd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c = C_SHR | C_DEC | (((m_q & 1) == 1) ? C_ADD : 15'h0);
        end
        @(negedge clk); reset = 1'b1; c = '0;
        @(negedge clk); reset = 1'b0;
        check("mid_rst_product", int'(product), 0);
        check("mid_rst_pvalid", int'(p_valid), 0);
        check("mid_rst_zq", int'(zq), 0);
        check("mid_rst_zy", int'(zy), 1);
        check("mid_rst_zr", int'(zr), 1);
        run_mult(5, 3, 16'h000F);

        run_mult(3, 5, 16'h000F);
        run_mult(-3, 5, 16'hFFF1);
        run_mult(5, -3, 16'hFFF1);
        run_mult(-128, -128, 16'h4000);
        run_mult(-128, 127, 16'hC080);
        run_mult(127, 127, 16'h3F01);
        run_mult(0, -1, 16'h0000);
        check("zr_zero_m", int'(zr), 1);

        // Single-bit multiplier LSB flag.
        @(negedge clk); c = C_LDQ; y = 8'sd1;
        @(negedge clk); check("zq_load", int'(zq), 1); c = C_SHR;
        @(negedge clk); check("zq_shift", int'(zq), 0); c = '0;

        // ADD and SUB together: SUB wins. F shows up in the following shift.
        @(negedge clk); c = C_LDM | C_LDQ | C_CLRA | C_CLRF; x = 8'sd2; y = 8'sd0;
        @(negedge clk); c = C_ADD | C_SUB;
        @(negedge clk); c = C_LATCH;
        @(negedge clk); check("addsub_a", int'(product) & 65535, 16'hFE00); c = C_SHR;
        @(negedge clk); c = C_LATCH;
        @(negedge clk); check("addsub_f", int'(product) & 65535, 16'hFF00); c = '0;

        // Clear, add and shift in one microinstruction.
        @(negedge clk); c = C_LDM | C_LDQ | C_CLRA | C_CLRF; x = 8'sh55; y = -8'sd1;
        @(negedge clk); c = C_ADD;
        @(negedge clk); c = C_LDM; x = 8'sd4;
        @(negedge clk); c = C_CLRA | C_ADD | C_SHR;
        @(negedge clk); c = C_LATCH;
        @(negedge clk); check("clr_add_shr", int'(product) & 65535, 16'h027F);

        // Back-to-back latches give back-to-back pulses.
        c = C_LATCH;
        @(negedge clk); check("b2b_pv1", int'(p_valid), 1); c = C_LATCH;
        @(negedge clk); check("b2b_pv2", int'(p_valid), 1); c = '0;
        @(negedge clk); check("b2b_pv3", int'(p_valid), 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
